// File: rtl/race_pkg.sv
// Shared types and helpers for the race-logic temporal less-than bank.
// Defines the channel FSM states and the event-polarity test.
package race_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    FIRE  = 2'd1,
    INHIB = 2'd2
  } race_st_e;

  localparam logic POL_RISE = 1'b0;
  localparam logic POL_FALL = 1'b1;

  function automatic logic active_lvl(
    input logic pol,
    input logic x
  );
    return (pol == POL_FALL) ? ~x : x;
  endfunction

endpackage

// File: rtl/race_lt_cell.sv
// One race-logic channel: latched a/b arrivals, WAIT/FIRE/INHIB FSM.
// Optional arrival timestamp under RACE_LT_TSTAMP_EN.
module race_lt_cell
  import race_pkg::*;
#(
  parameter int   T_W      = 8,
  parameter logic POL      = 1'b0,
  parameter logic TIE_PASS = 1'b0
) (
  input  logic           aclk,
  input  logic           rst,
  input  logic           grst,
  input  logic           a,
  input  logic           b,
`ifdef RACE_LT_TSTAMP_EN
  input  logic [T_W-1:0] t_now,
  output logic [T_W-1:0] t_q,
`endif
  output logic           q,
  output logic           res_d
);

  race_st_e st_q, st_d;
  logic     a_seen_q, a_seen_d;
  logic     b_seen_q, b_seen_d;
  logic     q_q, q_d;
  logic     a_arr, b_arr;

  assign a_arr = a_seen_q | active_lvl(POL, a);
  assign b_arr = b_seen_q | active_lvl(POL, b);

  always_comb begin
    st_d     = st_q;
    a_seen_d = a_arr;
    b_seen_d = b_arr;
    if (grst) begin
      st_d     = WAIT;
      a_seen_d = 1'b0;
      b_seen_d = 1'b0;
    end else if (st_q == WAIT) begin
      unique case (1'b1)
        a_arr && !b_arr: st_d = FIRE;
        b_arr && !a_arr: st_d = INHIB;
        a_arr && b_arr:  st_d = TIE_PASS ? FIRE : INHIB;
        default:         st_d = WAIT;
      endcase
    end
  end

  always_comb begin
    q_d   = (st_d == FIRE);
    res_d = (st_d != WAIT);
  end

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      st_q     <= WAIT;
      a_seen_q <= 1'b0;
      b_seen_q <= 1'b0;
      q_q      <= 1'b0;
    end else begin
      st_q     <= st_d;
      a_seen_q <= a_seen_d;
      b_seen_q <= b_seen_d;
      q_q      <= q_d;
    end
  end

  assign q = q_q;

`ifdef RACE_LT_TSTAMP_EN
  logic [T_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (grst)
      ts_d = '0;
    else if (st_q == WAIT && st_d == FIRE)
      ts_d = t_now;
  end

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_d;
  end

  assign t_q = ts_q;
`endif

endmodule

// File: rtl/race_lt_bank.sv
// Multi-channel temporal less-than bank with shared wave timer and done.
// Define RACE_LT_TSTAMP_EN to add per-channel arrival timestamps (t_q).
module race_lt_bank
  import race_pkg::*;
#(
  parameter int   N_CH     = 4,
  parameter int   T_W      = 8,
  parameter logic POL      = POL_RISE,
  parameter logic TIE_PASS = 1'b0
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic                grst,
  input  logic [N_CH-1:0]     a,
  input  logic [N_CH-1:0]     b,
`ifdef RACE_LT_TSTAMP_EN
  output logic [N_CH*T_W-1:0] t_q,
`endif
  output logic [N_CH-1:0]     q,
  output logic                done,
  output logic [T_W-1:0]      t_now
);

  localparam logic [T_W-1:0] T_MAX = '1;

  logic [T_W-1:0]  tmr_q, tmr_d;
  logic            done_q, done_d;
  logic [N_CH-1:0] res_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    race_lt_cell #(
      .T_W      (T_W),
      .POL      (POL),
      .TIE_PASS (TIE_PASS)
    ) u_cell (
      .aclk  (aclk),
      .rst   (rst),
      .grst  (grst),
      .a     (a[i]),
      .b     (b[i]),
`ifdef RACE_LT_TSTAMP_EN
      .t_now (tmr_q),
      .t_q   (t_q[i*T_W +: T_W]),
`endif
      .q     (q[i]),
      .res_d (res_d[i])
    );
  end

  // done tracks next-cycle state so it lines up with the resolving edge
  always_comb begin
    tmr_d  = '0;
    done_d = 1'b0;
    if (!grst) begin
      tmr_d  = (tmr_q == T_MAX) ? tmr_q : tmr_q + 1'b1;
      done_d = done_q | (&res_d) | (tmr_d == T_MAX);
    end
  end

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      tmr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      done_q <= done_d;
    end
  end

  assign t_now = tmr_q;
  assign done  = done_q;

endmodule

// File: tb/tb_race_lt_bank.sv
// Directed bench for race_lt_bank: four configurations run in lockstep.
// Covers strict/tie rules, falling polarity, timer saturation, async reset.
module tb_race_lt_bank;

  logic       aclk = 1'b0;
  logic       rst  = 1'b0;
  logic       grst = 1'b0;
  logic [3:0] a0 = '0, b0 = '0;
  logic [3:0] a2 = 4'hF, b2 = 4'hF;
  logic [3:0] a3 = '0, b3 = '0;

  logic [3:0] q0, q1, q2, q3;
  logic       d0, d1, d2, d3;
  logic [7:0] tn0, tn1, tn2;
  logic [2:0] tn3;
`ifdef RACE_LT_TSTAMP_EN
  logic [31:0] tq0, tq1, tq2;
  logic [11:0] tq3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  race_lt_bank #(.N_CH(4), .T_W(8), .POL(1'b0), .TIE_PASS(1'b0)) u0 (
    .aclk(aclk), .rst(rst), .grst(grst), .a(a0), .b(b0),
`ifdef RACE_LT_TSTAMP_EN
    .t_q(tq0),
`endif
    .q(q0), .done(d0), .t_now(tn0)
  );

  race_lt_bank #(.N_CH(4), .T_W(8), .POL(1'b0), .TIE_PASS(1'b1)) u1 (
    .aclk(aclk), .rst(rst), .grst(grst), .a(a0), .b(b0),
`ifdef RACE_LT_TSTAMP_EN
    .t_q(tq1),
`endif
    .q(q1), .done(d1), .t_now(tn1)
  );

  race_lt_bank #(.N_CH(4), .T_W(8), .POL(1'b1), .TIE_PASS(1'b0)) u2 (
    .aclk(aclk), .rst(rst), .grst(grst), .a(a2), .b(b2),
`ifdef RACE_LT_TSTAMP_EN
    .t_q(tq2),
`endif
    .q(q2), .done(d2), .t_now(tn2)
  );

  race_lt_bank #(.N_CH(4), .T_W(3), .POL(1'b0), .TIE_PASS(1'b0)) u3 (
    .aclk(aclk), .rst(rst), .grst(grst), .a(a3), .b(b3),
`ifdef RACE_LT_TSTAMP_EN
    .t_q(tq3),
`endif
    .q(q3), .done(d3), .t_now(tn3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wave();
    grst = 1'b1;
    tick();
    grst = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_q0", 32'(q0), 0);
    chk("rst_done0", 32'(d0), 0);
    chk("rst_t0", 32'(tn0), 0);
    chk("rst_t3", 32'(tn3), 0);
    tick();
    rst = 1'b1;
    wave();

    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("t0_k%0d", k), 32'(tn0), 32'(k));
      chk($sformatf("q0_k%0d", k), 32'(q0), {31'd0, k >= 4});
      chk($sformatf("q1_k%0d", k), 32'(q1),
          {29'd0, k >= 5, 1'b0, k >= 4});
      chk($sformatf("done0_k%0d", k), 32'(d0), 0);
      chk($sformatf("q2_k%0d", k), 32'(q2), {28'd0, k >= 5, 3'b000});
      chk($sformatf("done2_k%0d", k), 32'(d2), 0);
      chk($sformatf("t3_k%0d", k), 32'(tn3), (k < 7) ? k : 7);
      chk($sformatf("done3_k%0d", k), 32'(d3), {31'd0, k >= 7});
      case (k)
        2: b0[1] = 1'b1;
        3: a0[0] = 1'b1;
        4: begin a0[2] = 1'b1; b0[2] = 1'b1; a2[3] = 1'b0; end
        5: a0[1] = 1'b1;
        6: a2[3] = 1'b1;
        7: b0[0] = 1'b1;
        default: ;
      endcase
      tick();
    end

`ifdef RACE_LT_TSTAMP_EN
    chk("ts0_ch0", 32'(tq0[7:0]), 3);
    chk("ts0_ch2", 32'(tq0[23:16]), 0);
    chk("ts1_ch2", 32'(tq1[23:16]), 4);
    chk("ts2_ch3", 32'(tq2[31:24]), 4);
`endif

    a0 = '0;
    b0 = '0;
    wave();
    chk("gr_q0", 32'(q0), 0);
    chk("gr_t3", 32'(tn3), 0);
    chk("gr_done3", 32'(d3), 0);
    chk("gr_q2", 32'(q2), 0);

    a0 = 4'b0011;
    tick();
    chk("pre_q0", 32'(q0), 32'h3);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_q0", 32'(q0), 0);
    chk("arst_done0", 32'(d0), 0);
    chk("arst_t0", 32'(tn0), 0);
    chk("arst_t3", 32'(tn3), 0);
    #2 rst = 1'b1;
    tick();
    chk("post_t0", 32'(tn0), 1);
    chk("post_q0", 32'(q0), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_lt_bank.md
Name: race_lt_bank

Overview:
- Clocked, multi-channel successor to the single-pair temporal less-than primitive used in the race-logic datapath.
- Each of N_CH channels receives two race-encoded events, a[i] and b[i]. Output q[i] fires at a[i]'s arrival time only if a[i] arrived strictly before b[i]; with tie-pass enabled, a simultaneous arrival also fires.
- Events are sampled on aclk, and each computation wave is bounded by grst.
- A shared wave timer provides timeout and the done status for the downstream WTA/STDP stages.

Parameters:
- N_CH, 4, number of independent a/b channel pairs.
- T_W, 8, width of the wave timer in bits; the timer saturates at 2^T_W-1.
- POL, 0, event polarity: 0 = an event is a sampled 1 (rising-edge encoding); 1 = an event is a sampled 0 (falling-edge encoding).
- TIE_PASS, 0, tie rule: 0 = strict less-than, so a tie inhibits q; 1 = less-or-equal, so a tie fires q.

Ports:
- aclk, in, 1, the single clock; all logic is rising-edge.
- rst, in, 1, asynchronous active-low reset.
- grst, in, 1, synchronous gamma (wave) reset, active-high; starts a new wave.
- a, in, N_CH, per-channel a events, synchronous to aclk.
- b, in, N_CH, per-channel b events, synchronous to aclk.
- q, out, N_CH, per-channel temporal output, active-high, and level-held once fired.
- done, out, 1, high when every channel is resolved or the timer has saturated.
- t_now, out, T_W, current wave time in cycles since grst.

Behaviour:
- Reset (rst low, asynchronous): all outputs go low immediately: q=0, done=0, t_now=0. Every channel state is set to WAIT. This also applies mid-wave; the first cycle after rst deasserts behaves like the first cycle after a grst.
- grst high at a clock edge:
  - Next cycle: all channels are in WAIT, q=0, done=0, t_now=0.
  - Inputs sampled in the grst cycle are ignored.
  - grst takes priority over every event in the same cycle.
- Event detection:
  - a channel input is "arrived" in the first sampled cycle where it is at the active level (1 if POL=0, 0 if POL=1).
  - Arrival is latched: later deassertion or glitches are ignored until the next grst or rst.
- Per-channel FSM (states WAIT, FIRE, INHIB):
  - WAIT, a arrives and b does not in the same cycle -> FIRE.
  - WAIT, b arrives and a does not -> INHIB.
  - WAIT, a and b arrive in the same cycle -> FIRE if TIE_PASS=1, otherwise INHIB.
  - FIRE and INHIB are terminal until grst or rst.
- q[i] is registered: q[i] is 1 exactly while the channel is in FIRE, so it rises 1 cycle after a's arrival sample.
- Wave timer:
  - Increments each cycle after grst and saturates at 2^T_W-1 without wrapping.
  - t_now is the timer register itself.
- done:
  - Registered; set when all channels are in FIRE or INHIB, or when t_now==2^T_W-1.
  - Once set, done is held until grst or rst.
  - Channels still in WAIT at timeout stay in WAIT (q=0), but a late a-arrival still fires.
- Inputs that are already active in the first cycle after grst arrive at t=0.

Optional Feature:
- Macro RACE_LT_TSTAMP_EN.
- When defined, adds output port t_q (N_CH x T_W, packed). t_q[i] captures t_now at the cycle a[i] is sampled as arrived and the channel enters FIRE. It is 0 for channels that never fire and is cleared by grst or rst.
- When not defined, the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package race_pkg holds:
  - the enum race_st_e {WAIT, FIRE, INHIB};
  - the constants POL_RISE=0 and POL_FALL=1;
  - the function active_lvl(pol, x) returning the event test.
- Sub-module race_lt_cell holds one channel's FSM, latches and optional timestamp. It is instanced N_CH times with a generate loop. The timer and done logic stay in race_lt_bank.

Test Plan:
- rst low mid-wave while q=4'b0011 -> q=0, done=0 and t_now=0 asynchronously, before the next aclk edge.
- POL=0, grst, then a[0] high at t=3 and b[0] high at t=7 -> q[0] rises at t=4 and holds; with TSTAMP, t_q[0]=3.
- POL=0, b[1] high at t=2 and a[1] high at t=5 -> q[1] stays 0 for the whole wave; the channel is in INHIB.
- a[2] and b[2] high in the same cycle -> with TIE_PASS=0, q[2]=0; with TIE_PASS=1, q[2]=1 one cycle later.
- POL=1, all inputs start at 1; a[3] falls at t=4, then returns to 1 at t=6 -> q[3]=1 from t=5 and still held at t=6, since arrival is latched.
- T_W=3, no events -> t_now counts 0..7 and saturates at 7; done=1 from then on; then grst -> done=0 and t_now=0 the next cycle.
